// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default sizes, mode encodings and
// the state type used by the output serialiser.
package fft_pkg;

    localparam int DATA_W = 32;
    localparam int FFT_N  = 64;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SEQ    = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_e;

endpackage

// File: rtl/mux_n_to_1_seq_out_reg_hs.sv
// Single-entry valid/ready output register carrying data, index, last and error.
// A push loads a new word. It may coincide with the transfer of the current word.
// The error flag is a one-cycle pulse that follows the push. It is not held
// while the word waits for out_ready.
module out_reg_hs #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [IDXW-1:0]  idx_i,
    input  logic             last_i,
    input  logic             err_i,
    input  logic             ready_i,
    output logic             can_load_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [IDXW-1:0]  idx_o,
    output logic             last_o,
    output logic             err_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    // The register is free when it is empty or its word leaves this cycle.
    assign can_load_o = !valid_q || ready_i;

    // Load on push, otherwise drop valid after a transfer; payload holds while stalled.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        err_d   = 1'b0;
        if (push_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            idx_d   = idx_i;
            last_d  = last_i;
            err_d   = err_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

endmodule

// File: rtl/mux_n_to_1_seq.sv
// Registered N-to-1 word selector with a valid/ready output.
// Direct mode registers the word picked by sel. Sequence mode snapshots every
// channel and streams the channels out in index order 0..N-1.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a direct request or a sequence start
//   SEQ   | streaming the snapshot; cnt_q is the index held at the output
module mux_n_to_1_seq #(
    parameter int WIDTH = fft_pkg::DATA_W,
    parameter int N     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*WIDTH-1:0]     d_flat,
    input  logic                   mode,
    input  logic                   in_valid,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic                   start,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last,
    output logic                   sel_err,
    output logic                   busy
);

    import fft_pkg::*;

    localparam int              SELW     = $clog2(N);
    localparam logic [SELW:0]   N_L      = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(N-1);

    state_e             state_q, state_d;
    logic [SELW-1:0]    cnt_q, cnt_d;
    logic [N*WIDTH-1:0] snap_q, snap_d;

    logic               can_load;
    logic               xfer;
    logic               acc_direct;
    logic               acc_seq;
    logic               sel_oob;
    logic [SELW-1:0]    nxt_idx;
    logic [WIDTH-1:0]   sel_word;
    logic [WIDTH-1:0]   nxt_word;

    logic               push;
    logic [WIDTH-1:0]   push_data;
    logic [SELW-1:0]    push_idx;
    logic               push_last;
    logic               push_err;

    // Only one output register: new requests are taken only in IDLE when it is free.
    assign in_ready   = (state_q == IDLE) && can_load;
    assign xfer       = out_valid && out_ready;
    assign acc_direct = in_ready && (mode == MODE_DIRECT) && in_valid;
    assign acc_seq    = in_ready && (mode == MODE_SEQ) && start;
    assign sel_oob    = ({1'b0, sel} >= N_L);
    assign nxt_idx    = cnt_q + 1'b1;
    assign busy       = (state_q == SEQ);

    // Direct-mode channel pick; out-of-range selects fall through to zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                sel_word = d_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next word of a sequence, taken from the snapshot and never from the live inputs.
    always_comb begin
        nxt_word = '0;
        for (int k = 0; k < N; k++) begin
            if (nxt_idx == SELW'(k)) begin
                nxt_word = snap_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // FSM next state and output register load.
    // Channel 0 is loaded directly on the start edge. This gives one cycle of
    // latency without waiting for the snapshot register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        push      = 1'b0;
        push_data = '0;
        push_idx  = '0;
        push_last = 1'b0;
        push_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_direct) begin
                    push      = 1'b1;
                    push_data = sel_oob ? '0 : sel_word;
                    push_idx  = sel;
                    push_last = 1'b1;
                    push_err  = sel_oob;
                end else if (acc_seq) begin
                    snap_d    = d_flat;
                    cnt_d     = '0;
                    state_d   = SEQ;
                    push      = 1'b1;
                    push_data = d_flat[WIDTH-1:0];
                    push_idx  = '0;
                    push_last = 1'b0;
                end
            end
            SEQ: begin
                if (xfer) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d     = nxt_idx;
                        push      = 1'b1;
                        push_data = nxt_word;
                        push_idx  = nxt_idx;
                        push_last = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, sequence counter and snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
        end
    end

    out_reg_hs #(
        .WIDTH (WIDTH),
        .IDXW  (SELW)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .data_i     (push_data),
        .idx_i      (push_idx),
        .last_i     (push_last),
        .err_i      (push_err),
        .ready_i    (out_ready),
        .can_load_o (can_load),
        .valid_o    (out_valid),
        .data_o     (out_data),
        .idx_o      (out_idx),
        .last_o     (out_last),
        .err_o      (sel_err)
    );

endmodule

// File: tb/tb_mux_n_to_1_seq.sv
// Bench for mux_n_to_1_seq: an N=8/32-bit instance and an N=6/16-bit instance.
module tb_mux_n_to_1_seq;

    localparam int W1 = 32;
    localparam int N1 = 8;
    localparam int S1 = 3;
    localparam int W2 = 16;
    localparam int N2 = 6;
    localparam int S2 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N1*W1-1:0] d1;
    logic             mode1, in_valid1, start1, out_ready1;
    logic [S1-1:0]    sel1;
    logic             in_ready1, out_valid1, out_last1, sel_err1, busy1;
    logic [W1-1:0]    out_data1;
    logic [S1-1:0]    out_idx1;

    logic [N2*W2-1:0] d2;
    logic             mode2, in_valid2, start2, out_ready2;
    logic [S2-1:0]    sel2;
    logic             in_ready2, out_valid2, out_last2, sel_err2, busy2;
    logic [W2-1:0]    out_data2;
    logic [S2-1:0]    out_idx2;

    mux_n_to_1_seq #(.WIDTH(W1), .N(N1)) dut1 (
        .clk(clk), .rst_n(rst_n), .d_flat(d1), .mode(mode1), .in_valid(in_valid1),
        .sel(sel1), .start(start1), .in_ready(in_ready1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1), .out_idx(out_idx1),
        .out_last(out_last1), .sel_err(sel_err1), .busy(busy1)
    );

    mux_n_to_1_seq #(.WIDTH(W2), .N(N2)) dut2 (
        .clk(clk), .rst_n(rst_n), .d_flat(d2), .mode(mode2), .in_valid(in_valid2),
        .sel(sel2), .start(start2), .in_ready(in_ready2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_data(out_data2), .out_idx(out_idx2),
        .out_last(out_last2), .sel_err(sel_err2), .busy(busy2)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        int          idx;
        logic        last;
    } word_t;

    word_t obs1[$];
    word_t obs2[$];

    // Record every transfer; valid&ready seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        word_t w;
        if (rst_n && out_valid1 && out_ready1) begin
            w.data = out_data1; w.idx = int'(out_idx1); w.last = out_last1;
            obs1.push_back(w);
        end
        if (rst_n && out_valid2 && out_ready2) begin
            w.data = 32'(out_data2); w.idx = int'(out_idx2); w.last = out_last2;
            obs2.push_back(w);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] chan1(input logic [N1*W1-1:0] d, input int k);
        return d[k*W1 +: W1];
    endfunction

    function automatic logic [31:0] chan2(input logic [N2*W2-1:0] d, input int k);
        return 32'(d[k*W2 +: W2]);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid1, out_data1, out_idx1, out_last1, sel_err1, busy1} !== '0) begin
            failures++;
            $display("FAIL reset_outs1: got v=%b d=%h i=%0d l=%b e=%b b=%b expected all 0",
                     out_valid1, out_data1, out_idx1, out_last1, sel_err1, busy1);
        end
        checks++;
        if ({out_valid2, out_data2, out_idx2, out_last2, sel_err2, busy2} !== '0) begin
            failures++;
            $display("FAIL reset_outs2: got v=%b d=%h i=%0d expected all 0", out_valid2, out_data2, out_idx2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready1, in_ready2, out_valid1, out_valid2} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b%b vld=%b%b expected rdy=11 vld=00",
                     in_ready1, in_ready2, out_valid1, out_valid2);
        end
    endtask

    task automatic test_direct_sweep();
        for (int k = 0; k < N1; k++) d1[k*W1 +: W1] = 32'hA000_0000 + 32'(k);
        mode1 = 1'b0; out_ready1 = 1'b1; start1 = 1'b0;
        for (int i = 0; i <= N1; i++) begin
            @(posedge clk); #1;
            in_valid1 = (i < N1);
            sel1 = S1'(i % N1);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({out_valid1, out_data1, out_idx1, out_last1, sel_err1} !==
                    {1'b1, 32'hA000_0000 + 32'(i-1), S1'(i-1), 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL direct_word%0d: got v=%b d=%h i=%0d l=%b e=%b expected v=1 d=%h i=%0d l=1 e=0",
                             i-1, out_valid1, out_data1, out_idx1, out_last1, sel_err1,
                             32'hA000_0000 + 32'(i-1), i-1);
                end
            end
            if (i < N1) begin
                checks++;
                if (in_ready1 !== 1'b1) begin
                    failures++;
                    $display("FAIL direct_in_ready%0d: got %b expected 1", i, in_ready1);
                end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL direct_valid_drop: got %b expected 0", out_valid1);
        end
    endtask

    task automatic test_backpressure();
        obs1.delete();
        mode1 = 1'b0; out_ready1 = 1'b0;
        @(posedge clk); #1;
        in_valid1 = 1'b1; sel1 = 3'd5;
        @(posedge clk); #1;
        sel1 = 3'd2;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid1, out_data1, out_idx1, in_ready1} !== {1'b1, 32'hA000_0005, 3'd5, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b d=%h i=%0d rdy=%b expected v=1 d=a0000005 i=5 rdy=0",
                         c, out_valid1, out_data1, out_idx1, in_ready1);
            end
            @(posedge clk); #1;
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_data1, in_ready1} !== {32'hA000_0005, 1'b1}) begin
            failures++;
            $display("FAIL bp_release: got d=%h rdy=%b expected d=a0000005 rdy=1", out_data1, in_ready1);
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid1, out_data1, out_idx1} !== {1'b1, 32'hA000_0002, 3'd2}) begin
            failures++;
            $display("FAIL bp_second: got v=%b d=%h i=%0d expected v=1 d=a0000002 i=2",
                     out_valid1, out_data1, out_idx1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs1.size() != 2 || out_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL bp_count: got %0d words v=%b expected 2 words v=0", obs1.size(), out_valid1);
        end else begin
            checks++;
            if (obs1[0].idx != 5 || obs1[1].idx != 2) begin
                failures++;
                $display("FAIL bp_order: got %0d,%0d expected 5,2", obs1[0].idx, obs1[1].idx);
            end
        end
    endtask

    task automatic test_sequence();
        int busy_cnt = 0;
        for (int k = 0; k < N1; k++) d1[k*W1 +: W1] = 32'hA000_0000 + 32'(k);
        mode1 = 1'b1; out_ready1 = 1'b1; in_valid1 = 1'b0;
        obs1.delete();
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        d1 = '1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy1 === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            start1 = (c == 2);
        end
        start1 = 1'b0;
        checks++;
        if (busy_cnt != N1) begin
            failures++;
            $display("FAIL seq_busy: got %0d cycles expected %0d", busy_cnt, N1);
        end
        checks++;
        if (obs1.size() != N1) begin
            failures++;
            $display("FAIL seq_count: got %0d words expected %0d", obs1.size(), N1);
        end else begin
            for (int k = 0; k < N1; k++) begin
                checks++;
                if (obs1[k].data !== 32'hA000_0000 + 32'(k) || obs1[k].idx != k ||
                    obs1[k].last !== (k == N1-1)) begin
                    failures++;
                    $display("FAIL seq_word%0d: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                             k, obs1[k].data, obs1[k].idx, obs1[k].last,
                             32'hA000_0000 + 32'(k), k, (k == N1-1));
                end
            end
        end
    endtask

    task automatic test_seq_toggle();
        logic [N1*W1-1:0] snapd;
        for (int k = 0; k < N1; k++) d1[k*W1 +: W1] = $urandom();
        snapd = d1;
        mode1 = 1'b1; out_ready1 = 1'b1;
        obs1.delete();
        @(posedge clk); #1;
        start1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            for (int k = 0; k < N1; k++) d1[k*W1 +: W1] = $urandom();
            out_ready1 = (c % 2 == 0);
        end
        out_ready1 = 1'b1;
        checks++;
        if (obs1.size() != N1) begin
            failures++;
            $display("FAIL toggle_count: got %0d words expected %0d", obs1.size(), N1);
        end else begin
            for (int k = 0; k < N1; k++) begin
                checks++;
                if (obs1[k].data !== chan1(snapd, k) || obs1[k].idx != k) begin
                    failures++;
                    $display("FAIL toggle_word%0d: got d=%h i=%0d expected d=%h i=%0d",
                             k, obs1[k].data, obs1[k].idx, chan1(snapd, k), k);
                end
            end
        end
    endtask

    task automatic test_n6();
        logic [N2*W2-1:0] snapd;
        mode2 = 1'b0; out_ready2 = 1'b1; start2 = 1'b0;
        for (int k = 0; k < N2; k++) d2[k*W2 +: W2] = 16'($urandom());
        for (int s = 6; s <= 7; s++) begin
            @(posedge clk); #1;
            in_valid2 = 1'b1; sel2 = S2'(s);
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            @(negedge clk);
            checks++;
            if ({out_valid2, out_data2, out_idx2, out_last2, sel_err2} !== {1'b1, 16'h0, S2'(s), 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL n6_oob_sel%0d: got v=%b d=%h i=%0d l=%b e=%b expected v=1 d=0000 i=%0d l=1 e=1",
                         s, out_valid2, out_data2, out_idx2, out_last2, sel_err2, s);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ({out_valid2, sel_err2} !== 2'b00) begin
                failures++;
                $display("FAIL n6_err_pulse%0d: got v=%b e=%b expected v=0 e=0", s, out_valid2, sel_err2);
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < N2; k++) d2[k*W2 +: W2] = 16'($urandom());
        snapd = d2;
        mode2 = 1'b1;
        obs2.delete();
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        d2 = '0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (obs2.size() != N2) begin
            failures++;
            $display("FAIL n6_count: got %0d words expected %0d", obs2.size(), N2);
        end else begin
            for (int k = 0; k < N2; k++) begin
                checks++;
                if (obs2[k].data !== chan2(snapd, k) || obs2[k].idx != k ||
                    obs2[k].last !== (k == N2-1)) begin
                    failures++;
                    $display("FAIL n6_word%0d: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                             k, obs2[k].data, obs2[k].idx, obs2[k].last, chan2(snapd, k), k, (k == N2-1));
                end
            end
        end
        checks++;
        if ({busy2, out_valid2, in_ready2} !== 3'b001) begin
            failures++;
            $display("FAIL n6_end: got b=%b v=%b rdy=%b expected b=0 v=0 rdy=1", busy2, out_valid2, in_ready2);
        end
    endtask

    task automatic test_reset_mid_seq();
        bit found = 0;
        mode1 = 1'b1; out_ready1 = 1'b1; in_valid1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = (out_valid1 === 1'b1 && out_idx1 === 3'd3);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_mid_reach: got no word at idx 3 expected one within 20 cycles");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid1, out_data1, out_idx1, out_last1, sel_err1, busy1} !== '0) begin
            failures++;
            $display("FAIL rst_mid_async: got v=%b d=%h i=%0d l=%b e=%b b=%b expected all 0",
                     out_valid1, out_data1, out_idx1, out_last1, sel_err1, busy1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid1, in_ready1, busy1} !== 3'b010) begin
                failures++;
                $display("FAIL rst_mid_after%0d: got v=%b rdy=%b b=%b expected v=0 rdy=1 b=0",
                         c, out_valid1, in_ready1, busy1);
            end
        end
    endtask

    task automatic test_random();
        word_t pend[$];
        word_t w;
        bit    seq_act = 0;
        bit    err_exp = 0;
        bit    exp_ready;
        @(negedge clk);
        rst_n = 1'b0;
        in_valid1 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            mode1      = 1'($urandom_range(0, 1));
            in_valid1  = 1'($urandom_range(0, 1));
            start1     = ($urandom_range(0, 3) == 0);
            sel1       = S1'($urandom_range(0, N1-1));
            out_ready1 = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N1; k++) d1[k*W1 +: W1] = $urandom();
            @(negedge clk);
            exp_ready = !seq_act && (pend.size() == 0 || out_ready1);
            checks++;
            if (out_valid1 !== (pend.size() > 0)) begin
                failures++;
                $display("FAIL rand_valid@%0d: got %b expected %b", cyc, out_valid1, pend.size() > 0);
            end else if (pend.size() > 0) begin
                checks++;
                if (out_data1 !== pend[0].data || int'(out_idx1) != pend[0].idx || out_last1 !== pend[0].last) begin
                    failures++;
                    $display("FAIL rand_word@%0d: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                             cyc, out_data1, out_idx1, out_last1, pend[0].data, pend[0].idx, pend[0].last);
                end
            end
            checks++;
            if ({in_ready1, busy1, sel_err1} !== {exp_ready, seq_act, err_exp}) begin
                failures++;
                $display("FAIL rand_ctrl@%0d: got rdy=%b b=%b e=%b expected rdy=%b b=%b e=%b",
                         cyc, in_ready1, busy1, sel_err1, exp_ready, seq_act, err_exp);
            end
            err_exp = 0;
            if (pend.size() > 0 && out_ready1) begin
                void'(pend.pop_front());
                if (pend.size() == 0) seq_act = 0;
            end
            if (exp_ready) begin
                if (mode1 == 1'b0 && in_valid1) begin
                    err_exp = (int'(sel1) >= N1);
                    w.data = err_exp ? 32'h0 : chan1(d1, int'(sel1));
                    w.idx = int'(sel1); w.last = 1'b1;
                    pend.push_back(w);
                end else if (mode1 == 1'b1 && start1) begin
                    for (int k = 0; k < N1; k++) begin
                        w.data = chan1(d1, k); w.idx = k; w.last = (k == N1-1);
                        pend.push_back(w);
                    end
                    seq_act = 1;
                end
            end
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0; start1 = 1'b0;
    endtask

    initial begin
        d1 = '0; mode1 = 1'b0; in_valid1 = 1'b0; start1 = 1'b0; out_ready1 = 1'b1; sel1 = '0;
        d2 = '0; mode2 = 1'b0; in_valid2 = 1'b0; start2 = 1'b0; out_ready2 = 1'b1; sel2 = '0;
        test_reset();
        test_direct_sweep();
        test_backpressure();
        test_sequence();
        test_seq_toggle();
        test_n6();
        test_reset_mid_seq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
